// File: rtl/melody_player.sv
// melody_player: steps a fixed ROM of (note, duration) pairs for the game sound effects, with a silent gap per step.
// Outputs update the cycle after play_req and are all registered; there is no backpressure, and stop/play_req act at once.
module melody_player #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int TICK_HZ    = 1000,
  parameter int UNIT_TICKS = 25,
  parameter int GAP_TICKS  = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       play_req,
  input  logic [1:0] melody_sel,
  input  logic       stop,
  output logic [3:0] note,
  output logic       note_en,
  output logic       busy,
  output logic       done
);

  localparam int TICK_CLKS = CLK_FREQ / TICK_HZ;
  localparam int TICK_W    = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int DUR_W     = $clog2(15 * UNIT_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SOUND, GAP} state_t;

  state_t             state;
  logic [TICK_W-1:0]  tick_cnt;
  logic [DUR_W-1:0]   dur_cnt;
  logic [2:0]         step;
  logic [1:0]         mel;
  logic [3:0]         cur_note;
  logic [3:0]         cur_dur;

  logic               tick_wrap;
  logic [DUR_W-1:0]   sound_last;
  logic [DUR_W-1:0]   gap_last;
  logic [7:0]         first_entry;
  logic [7:0]         next_entry;

  // Entry layout is {note, dur}; dur == 0 terminates the melody.
  function automatic logic [7:0] rom_entry(input logic [1:0] mel_i, input logic [2:0] step_i);
    logic [7:0] e;
    e = 8'h00;
    case ({mel_i, step_i})
      5'b00_000: e = 8'h82;
      5'b01_000: e = 8'h94;
      5'b01_001: e = 8'hA8;
      5'b10_000: e = 8'h14;
      5'b10_001: e = 8'h34;
      5'b10_010: e = 8'h54;
      5'b10_011: e = 8'h7C;
      5'b11_000: e = 8'h54;
      5'b11_001: e = 8'h44;
      5'b11_010: e = 8'h34;
      5'b11_011: e = 8'h24;
      5'b11_100: e = 8'h18;
      default:   e = 8'h00;
    endcase
    return e;
  endfunction

  assign tick_wrap   = (tick_cnt == TICK_W'(TICK_CLKS - 1));
  assign sound_last  = DUR_W'(int'(cur_dur) * UNIT_TICKS - GAP_TICKS - 1);
  assign gap_last    = DUR_W'(GAP_TICKS - 1);
  assign first_entry = rom_entry(melody_sel, 3'd0);
  assign next_entry  = rom_entry(mel, step + 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      step     <= '0;
      mel      <= '0;
      cur_note <= '0;
      cur_dur  <= '0;
      note     <= '0;
      note_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (stop) begin
      // Stop has priority over a simultaneous request; in IDLE this is a no-op.
      state    <= IDLE;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      step     <= '0;
      note     <= '0;
      note_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (play_req) begin
      state    <= SOUND;
      tick_cnt <= '0;
      dur_cnt  <= '0;
      step     <= '0;
      mel      <= melody_sel;
      cur_note <= first_entry[7:4];
      cur_dur  <= first_entry[3:0];
      note     <= first_entry[7:4];
      note_en  <= (first_entry[7:4] != 4'd0);
      busy     <= 1'b1;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
        end
        SOUND: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            if (dur_cnt == sound_last) begin
              state   <= GAP;
              dur_cnt <= '0;
              note    <= '0;
              note_en <= 1'b0;
            end else begin
              dur_cnt <= dur_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        GAP: begin
          if (tick_wrap) begin
            tick_cnt <= '0;
            if (dur_cnt == gap_last) begin
              dur_cnt <= '0;
              if (step == 3'd7 || next_entry[3:0] == 4'd0) begin
                state <= IDLE;
                step  <= '0;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state    <= SOUND;
                step     <= step + 3'd1;
                cur_note <= next_entry[7:4];
                cur_dur  <= next_entry[3:0];
                note     <= next_entry[7:4];
                note_en  <= (next_entry[7:4] != 4'd0);
              end
            end else begin
              dur_cnt <= dur_cnt + 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_player.sv
// Randomized scoreboard bench for melody_player: a timeline model queues expected output changes, a monitor checks them.
module tb_melody_player;

  localparam int CLK_FREQ   = 100;
  localparam int TICK_HZ    = 10;
  localparam int UNIT_TICKS = 2;
  localparam int GAP_TICKS  = 1;
  localparam int TC         = CLK_FREQ / TICK_HZ;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       play_req;
  logic [1:0] melody_sel;
  logic       stop;
  logic [3:0] note;
  logic       note_en;
  logic       busy;
  logic       done;

  melody_player #(
    .CLK_FREQ  (CLK_FREQ),
    .TICK_HZ   (TICK_HZ),
    .UNIT_TICKS(UNIT_TICKS),
    .GAP_TICKS (GAP_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .play_req  (play_req),
    .melody_sel(melody_sel),
    .stop      (stop),
    .note      (note),
    .note_en   (note_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Melody table: drop, invalid, win, draw. Duration 0 ends a melody.
  int mel_note [4][8] = '{'{8, 0, 0, 0, 0, 0, 0, 0},
                          '{9, 10, 0, 0, 0, 0, 0, 0},
                          '{1, 3, 5, 7, 0, 0, 0, 0},
                          '{5, 4, 3, 2, 1, 0, 0, 0}};
  int mel_dur  [4][8] = '{'{2, 0, 0, 0, 0, 0, 0, 0},
                          '{4, 8, 0, 0, 0, 0, 0, 0},
                          '{4, 4, 4, 12, 0, 0, 0, 0},
                          '{4, 4, 4, 4, 8, 0, 0, 0}};

  // Output tuple is {done, busy, note_en, note}; an event is a change of that tuple at a cycle.
  typedef struct {
    logic [6:0] tup;
    int         cyc;
  } ev_t;

  ev_t sb_q[$];
  ev_t hist[$];

  function automatic logic [6:0] mk(input bit d, input bit b, input bit e, input logic [3:0] n);
    return {d, b, e, n};
  endfunction

  function automatic logic [6:0] exp_last();
    if (hist.size() == 0) return 7'd0;
    return hist[hist.size()-1].tup;
  endfunction

  function automatic logic [6:0] exp_at(input int t);
    for (int i = hist.size() - 1; i >= 0; i--)
      if (hist[i].cyc <= t) return hist[i].tup;
    return 7'd0;
  endfunction

  task automatic truncate(input int t);
    while (hist.size() > 0 && hist[hist.size()-1].cyc > t) void'(hist.pop_back());
    while (sb_q.size() > 0 && sb_q[sb_q.size()-1].cyc > t) void'(sb_q.pop_back());
  endtask

  task automatic push_ev(input logic [6:0] t, input int c);
    ev_t e;
    if (t != exp_last()) begin
      e.tup = t;
      e.cyc = c;
      hist.push_back(e);
      sb_q.push_back(e);
    end
  endtask

  // Timeline of a melody requested in cycle t0, straight from the step timing rules.
  task automatic expect_melody(input int m, input int t0);
    int c;
    int n;
    int d;
    c = t0 + 1;
    for (int k = 0; k < 8; k++) begin
      n = mel_note[m][k];
      d = mel_dur[m][k];
      if (d == 0) break;
      push_ev(mk(1'b0, 1'b1, n != 0, 4'(n)), c);
      c += (d * UNIT_TICKS - GAP_TICKS) * TC;
      push_ev(mk(1'b0, 1'b1, 1'b0, 4'd0), c);
      c += GAP_TICKS * TC;
    end
    push_ev(mk(1'b1, 1'b0, 1'b0, 4'd0), c);
    push_ev(7'd0, c + 1);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic do_play(input int m);
    truncate(cyc);
    expect_melody(m, cyc);
    play_req   = 1'b1;
    melody_sel = 2'(m);
    next_cycle();
    play_req   = 1'b0;
  endtask

  task automatic do_stop(input bit with_play, input int m);
    logic [6:0] now_t;
    now_t = exp_at(cyc);
    if (now_t[5]) begin
      truncate(cyc);
      push_ev(7'd0, cyc + 1);
    end
    stop       = 1'b1;
    play_req   = with_play;
    melody_sel = 2'(m);
    next_cycle();
    stop       = 1'b0;
    play_req   = 1'b0;
  endtask

  task automatic do_reset();
    truncate(cyc - 1);
    push_ev(7'd0, cyc);
    rst_n = 1'b0;
    #1;
    chk("reset_note", {28'd0, note}, 32'd0);
    chk("reset_note_en", {31'd0, note_en}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    wait_cycles(2);
    rst_n = 1'b1;
  endtask

  // Monitor: every change of the output tuple must match the next queued expectation.
  bit         mon_en = 1'b0;
  logic [6:0] prev = 7'd0;
  always @(negedge clk) begin
    logic [6:0] cur;
    ev_t        e;
    if (mon_en) begin
      cur = {done, busy, note_en, note};
      if (!note_en) chk("note_zero_when_off", {28'd0, note}, 32'd0);
      if (cur !== prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change at cycle %0d: got tuple %0h, expected no change", cyc, cur);
        end else begin
          e = sb_q.pop_front();
          chk("output_event", {cur, 25'(cyc)}, {e.tup, 25'(e.cyc)});
        end
      end
      prev = cur;
    end
  end

  initial begin
    int t0;
    int r;
    rst_n      = 1'b0;
    play_req   = 1'b0;
    melody_sel = 2'd0;
    stop       = 1'b0;
    wait_cycles(3);
    chk("init_note", {28'd0, note}, 32'd0);
    chk("init_note_en", {31'd0, note_en}, 32'd0);
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_done", {31'd0, done}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_cycles(2);

    // Drop, then win played to completion.
    do_play(0);
    wait_cycles(50);
    do_play(2);
    wait_cycles(500);

    // Draw pre-empted by drop at cycle 50 of the draw.
    t0 = cyc;
    do_play(3);
    wait_cycles(49);
    chk("preempt_busy", {31'd0, busy}, 32'd1);
    do_play(0);
    chk("preempt_note", {28'd0, note}, 32'd8);
    wait_cycles(50);

    // Stop at cycle 20 of invalid.
    do_play(1);
    wait_cycles(19);
    do_stop(1'b0, 0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_note_en", {31'd0, note_en}, 32'd0);
    wait_cycles(5);

    // Stop and request together from IDLE: stays idle.
    do_stop(1'b1, 2);
    chk("stop_play_idle_busy", {31'd0, busy}, 32'd0);
    wait_cycles(5);

    // Back-to-back: new request in the done cycle.
    t0 = cyc;
    do_play(0);
    wait_cycles(40);
    chk("b2b_done_cycle", {31'd0, done}, 32'd1);
    do_play(1);
    chk("b2b_note_en", {31'd0, note_en}, 32'd1);
    chk("b2b_note", {28'd0, note}, 32'd9);
    wait_cycles(30);

    // Reset in the middle of a melody.
    do_reset();
    wait_cycles(5);

    for (int it = 0; it < 40; it++) begin
      wait_cycles($urandom_range(0, 150));
      r = $urandom_range(0, 9);
      if (r <= 5)      do_play($urandom_range(0, 3));
      else if (r <= 7) do_stop(1'b0, 0);
      else if (r == 8) do_stop(1'b1, $urandom_range(0, 3));
      else             do_reset();
    end

    wait_cycles(520);
    chk("queue_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
